// File: rtl/global_mem_mp.sv
// Multi-read-port, byte-writable global-variable store with write-first forwarding and zero-init sweep.
// Optional per-byte parity storage and checking when GLOBAL_MEM_PARITY_EN is defined.
module global_mem_mp #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 256,
  parameter int NUM_RD     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           init_busy,
  input  logic [NUM_RD-1:0]              rd_req,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_RD-1:0]              rd_vld,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
  input  logic                           we,
  output logic                           wr_ready,
  input  logic [DATA_WIDTH/8-1:0]        wr_be,
  input  logic [ADDR_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
`ifdef GLOBAL_MEM_PARITY_EN
  output logic [NUM_RD-1:0]              par_err,
`endif
  output logic                           oob_err
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   cnt_reg, cnt_next;
  logic                    run;
  logic                    wr_oob, wr_en;
  logic [DATA_WIDTH-1:0]   wr_mask;
  logic [NUM_RD-1:0]       rd_oob;
  logic                    oob_reg;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
`ifdef GLOBAL_MEM_PARITY_EN
  logic [BE_WIDTH-1:0]     par_mem [DEPTH];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == CLEAR) begin
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == LAST_IDX) begin
        state_next = RUN;
        cnt_next   = '0;
      end
    end
  end

  always_comb begin
    init_busy = (state_reg == CLEAR);
    wr_ready  = (state_reg == RUN);
  end

  assign run    = (state_reg == RUN);
  assign wr_oob = ({1'b0, wr_addr} >= DEPTH_W);
  assign wr_en  = run & we & ~wr_oob;

  genvar gi;
  generate
    for (gi = 0; gi < BE_WIDTH; gi++) begin : g_mask
      assign wr_mask[gi*8 +: 8] = {8{wr_be[gi]}};
    end
  endgenerate

  // The clear sweep shares the single write port; no reset on the array itself.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt_reg] <= '0;
`ifdef GLOBAL_MEM_PARITY_EN
      par_mem[cnt_reg] <= '0;
`endif
    end else if (wr_en) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (wr_be[b]) begin
          mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
`ifdef GLOBAL_MEM_PARITY_EN
          par_mem[wr_addr][b] <= ^wr_data[b*8 +: 8];
`endif
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic                  oob, fwd, acc;
      logic [DATA_WIDTH-1:0] raw_q, fwd_data_q, fwd_mask_q;
      logic                  vld_reg, zero_reg;

      assign addr = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign oob  = ({1'b0, addr} >= DEPTH_W);
      assign fwd  = wr_en && (wr_addr == addr);
      assign acc  = run & rd_req[gi];
      assign rd_oob[gi] = oob;

      // Plain registered array read; the forwarding merge happens after the register.
      always_ff @(posedge clk) begin
        if (acc) begin
          raw_q      <= mem[addr];
          fwd_data_q <= wr_data;
          fwd_mask_q <= fwd ? wr_mask : '0;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_reg  <= 1'b0;
          zero_reg <= 1'b1;
        end else begin
          vld_reg <= acc;
          if (acc) zero_reg <= oob;
        end
      end

      assign rd_vld[gi] = vld_reg;
      assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        zero_reg ? '0 : ((raw_q & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q));

`ifdef GLOBAL_MEM_PARITY_EN
      logic [BE_WIDTH-1:0] par_q, par_calc;
      logic                chk_reg;

      always_ff @(posedge clk) begin
        if (acc) par_q <= par_mem[addr];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) chk_reg <= 1'b0;
        else if (acc) chk_reg <= ~oob & ~fwd;
      end

      always_comb begin
        par_calc = '0;
        for (int b = 0; b < BE_WIDTH; b++) par_calc[b] = ^raw_q[b*8 +: 8];
      end

      assign par_err[gi] = vld_reg & chk_reg & (par_calc != par_q);
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) oob_reg <= 1'b0;
    else     oob_reg <= run & ((we & wr_oob) | (|(rd_req & rd_oob)));
  end

  assign oob_err = oob_reg;

endmodule

// File: tb/tb_global_mem_mp.sv
// Scoreboard bench for global_mem_mp: random and directed traffic against an array model.
module tb_global_mem_mp;
  localparam int AW = 8, DW = 64, DEPTH = 200, NR = 2, BW = DW / 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             init_busy;
  logic [NR-1:0]    rd_req = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR-1:0]    rd_vld;
  logic [NR*DW-1:0] rd_data;
  logic             we = 1'b0;
  logic             wr_ready;
  logic [BW-1:0]    wr_be = '0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             oob_err;
`ifdef GLOBAL_MEM_PARITY_EN
  logic [NR-1:0]    par_err;
`endif

  global_mem_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NR)) dut (
    .clk(clk), .rst(rst), .init_busy(init_busy),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_vld(rd_vld), .rd_data(rd_data),
    .we(we), .wr_ready(wr_ready), .wr_be(wr_be), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef GLOBAL_MEM_PARITY_EN
    .par_err(par_err),
`endif
    .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [DW-1:0] d;} exp_t;

  int            tests = 0, fails = 0, cyc = 0;
  bit            mon_en = 0;
  exp_t          rq[NR][$];
  int            oob_q[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last [NR];
  exp_t          mon_e;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: each cycle, outputs must match exactly what the scoreboard says is due now.
  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < NR; p++) last[p] = '0;
    end else if (mon_en) begin
      for (int p = 0; p < NR; p++) begin
        while (rq[p].size() > 0 && rq[p][0].cyc < cyc) begin
          tests++; fails++;
          $display("FAIL missed_read[%0d]: got no rd_vld expected one at cycle %0d", p, rq[p][0].cyc);
          void'(rq[p].pop_front());
        end
        if (rq[p].size() > 0 && rq[p][0].cyc == cyc) begin
          mon_e = rq[p].pop_front();
          chk($sformatf("rd_vld[%0d]", p), 64'(rd_vld[p]), 64'd1);
          chk($sformatf("rd_data[%0d]", p), rd_data[p*DW +: DW], mon_e.d);
          last[p] = mon_e.d;
        end else begin
          chk($sformatf("rd_vld_idle[%0d]", p), 64'(rd_vld[p]), 64'd0);
          chk($sformatf("rd_data_hold[%0d]", p), rd_data[p*DW +: DW], last[p]);
        end
      end
      if (oob_q.size() > 0 && oob_q[0] == cyc) begin
        void'(oob_q.pop_front());
        chk("oob_err", 64'(oob_err), 64'd1);
      end else begin
        chk("oob_err_idle", 64'(oob_err), 64'd0);
      end
`ifdef GLOBAL_MEM_PARITY_EN
      chk("par_err", 64'(par_err), 64'd0);
`endif
    end
  end

  // One transaction cycle: apply write to the model first (write-first), then queue reads.
  task automatic issue(input bit w, input logic [AW-1:0] wa, input logic [BW-1:0] be,
                       input logic [DW-1:0] wd, input logic [NR-1:0] rv,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    logic [AW-1:0] ra [NR];
    bit            oob;
    exp_t          e;
    ra[0] = a0; ra[1] = a1;
    we = w; wr_addr = wa; wr_be = be; wr_data = wd; rd_req = rv; rd_addr = {a1, a0};
    oob = 0;
    if (w) begin
      if (int'(wa) >= DEPTH) oob = 1;
      else for (int b = 0; b < BW; b++) if (be[b]) model[int'(wa)][b*8 +: 8] = wd[b*8 +: 8];
    end
    for (int p = 0; p < NR; p++) begin
      if (rv[p]) begin
        if (int'(ra[p]) >= DEPTH) begin oob = 1; e.d = '0; end
        else e.d = model[int'(ra[p])];
        e.cyc = cyc + 1;
        rq[p].push_back(e);
      end
    end
    if (oob) oob_q.push_back(cyc + 1);
    @(posedge clk); #1;
    we = 0; rd_req = '0;
  endtask

  task automatic check_reset();
    chk("rst_init_busy", 64'(init_busy), 64'd1);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_rd_vld", 64'(rd_vld), 64'd0);
    for (int p = 0; p < NR; p++) chk("rst_rd_data", rd_data[p*DW +: DW], 64'd0);
    chk("rst_oob_err", 64'(oob_err), 64'd0);
  endtask

  // Counts busy cycles while throwing junk traffic that must be ignored.
  task automatic clear_wait();
    int n = 0;
    while (init_busy === 1'b1 && n < 1000) begin
      chk("clear_wr_ready", 64'(wr_ready), 64'd0);
      n++;
      we = 1'($urandom); rd_req = NR'($urandom); wr_be = BW'($urandom);
      wr_addr = AW'($urandom); rd_addr = (NR*AW)'($urandom); wr_data = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    we = 0; rd_req = '0;
    chk("init_busy_cycles", 64'(n), 64'(DEPTH));
    chk("run_wr_ready", 64'(wr_ready), 64'd1);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic random_traffic(input int n);
    logic [AW-1:0] wa, a0, a1;
    logic [BW-1:0] be;
    for (int i = 0; i < n; i++) begin
      wa = ($urandom_range(0, 4) == 0) ? AW'($urandom) : AW'($urandom_range(0, DEPTH - 1));
      case ($urandom_range(0, 3))
        0: be = '0;
        1: be = '1;
        default: be = BW'($urandom);
      endcase
      a0 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
      a1 = ($urandom_range(0, 2) == 0) ? a0 : AW'($urandom);
      issue(1'($urandom), wa, be, {$urandom, $urandom}, NR'($urandom), a0, a1);
    end
  endtask

  initial begin
    #1 rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check_reset();
    rst = 0;
    mon_en = 1;
    clear_wait();

    issue(0, 0, 0, 0, 2'b11, 8'h37, 8'h37);                        // cleared entry reads 0
    for (int a = 0; a < DEPTH; a++) issue(1, AW'(a), '1, {$urandom, $urandom}, 0, 0, 0);
    issue(1, 5, 8'hFF, 64'h1122334455667788, 0, 0, 0);
    issue(1, 5, 8'h01, 64'hAAAAAAAAAAAAAAAA, 0, 0, 0);
    issue(0, 0, 0, 0, 2'b11, 5, 5);                                // 11223344556677AA
    issue(1, 9, 8'hFF, 64'h1234, 0, 0, 0);
    issue(1, 9, 8'hF0, 64'hFFFF_FFFF_0000_0000, 2'b11, 9, 9);      // forwarded FFFFFFFF00001234
    issue(1, 210, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 0, 0, 0);        // dropped write
    issue(0, 0, 0, 0, 2'b01, 250, 0);
    issue(0, 0, 0, 0, 2'b11, 210, 8'd199);
    issue(1, 199, 8'hFF, 64'h5A5A, 2'b10, 0, 255);
    issue(0, 0, 0, 0, 2'b11, 199, 199);
    random_traffic(400);
    repeat (3) issue(0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a clear sweep; the sweep must start over at entry 0.
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    repeat (100) @(posedge clk);
    #1 rst = 1;
    #1 check_reset();
    @(posedge clk); #1;
    rst = 0;
    clear_wait();
    for (int a = 0; a < DEPTH; a += 2) issue(0, 0, 0, 0, 2'b11, AW'(a), AW'(a + 1));
    random_traffic(150);
    repeat (3) issue(0, 0, 0, 0, 0, 0, 0);

    chk("pending_reads", 64'(rq[0].size() + rq[1].size()), 64'd0);
    chk("pending_oob", 64'(oob_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
